// File: rtl/packet_tx_sched.sv
// packet_tx_sched: snapshots a PKT_W-bit frame on frame_tick and streams it LSB-byte-first over tx_valid/tx_ready; 1 cycle tick-to-valid,
// bytes held stable while tx_ready is low, ticks arriving mid-frame are dropped and counted. `define PACKET_CHECKSUM_EN appends a mod-256 sum byte.
module packet_tx_sched #(
  parameter int PKT_W     = 176,
  parameter int NUM_BYTES = PKT_W / 8,
  parameter int BYTE_GAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [PKT_W-1:0] packet,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       drop_cnt
);

`ifdef PACKET_CHECKSUM_EN
  localparam int XFERS = NUM_BYTES + 1;
`else
  localparam int XFERS = NUM_BYTES;
`endif
  localparam int               IDX_W    = $clog2(XFERS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFERS - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(BYTE_GAP);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e           state_q;
  logic [PKT_W-1:0] shadow_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       gap_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       drop_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] idx_d;
  logic [7:0]       byte_d;

  assign idx_d = idx_q + 1'b1;

`ifdef PACKET_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  // Running sum includes the byte transferring this edge, so the checksum is ready right after the last data byte.
  assign sum_d = sum_q + tx_data_q;
`endif

  always_comb begin
    byte_d = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx_d == IDX_W'(k)) byte_d = shadow_q[8*k +: 8];
    end
`ifdef PACKET_CHECKSUM_EN
    if (idx_d == IDX_W'(NUM_BYTES)) byte_d = sum_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= '0;
`ifdef PACKET_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // Any tick outside IDLE is an overrun, including one on the final transfer edge.
      if (frame_tick && state_q != IDLE && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            shadow_q   <= packet;
            idx_q      <= '0;
            tx_data_q  <= packet[7:0];
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
`ifdef PACKET_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end
        end
        SEND: begin
          if (tx_ready) begin
`ifdef PACKET_CHECKSUM_EN
            sum_q <= sum_d;
`endif
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= byte_d;
              if (BYTE_GAP != 0) begin
                tx_valid_q <= 1'b0;
                gap_q      <= GAP_LOAD;
                state_q    <= GAP;
              end
            end
          end
        end
        GAP: begin
          // Byte is re-offered on the cycle the count hits 1, giving exactly BYTE_GAP low cycles.
          if (gap_q == 8'd1) begin
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_packet_tx_sched.sv
// Scoreboard bench for packet_tx_sched: stimulus pushes expected bytes, a negedge monitor pops and checks them;
// a second instance with BYTE_GAP=3 covers inter-byte gaps.
module tb_packet_tx_sched;
  localparam int PKT_W = 176;
  localparam int NB    = PKT_W / 8;
`ifdef PACKET_CHECKSUM_EN
  localparam int XF = NB + 1;
`else
  localparam int XF = NB;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_tick = 1'b0;
  logic             frame_tick_g = 1'b0;
  logic             tx_ready = 1'b0;
  logic [PKT_W-1:0] packet = '0;
  logic [7:0]       tx_data, tx_data_g, drop_cnt, drop_cnt_g;
  logic             tx_valid, busy, frame_done;
  logic             tx_valid_g, busy_g, frame_done_g;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } exp_t;
  exp_t exp_q[$];
  logic pend_done = 1'b0;

  logic [PKT_W-1:0] pk_hdr, pk_cnt, pk_ff;

  always #5 clk = ~clk;

  packet_tx_sched #(.PKT_W(PKT_W)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .packet(packet), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  packet_tx_sched #(.PKT_W(PKT_W), .BYTE_GAP(3)) dut_g (
    .clk(clk), .rst(rst), .frame_tick(frame_tick_g), .packet(packet), .tx_ready(tx_ready),
    .tx_data(tx_data_g), .tx_valid(tx_valid_g), .busy(busy_g), .frame_done(frame_done_g), .drop_cnt(drop_cnt_g)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] csum_of(input logic [PKT_W-1:0] p);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < NB; k++) s = s + p[8*k +: 8];
    return s;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [PKT_W-1:0] p, input int k, input logic [7:0] cs);
    logic [7:0] b = cs;
    if (k < NB) b = p[8*k +: 8];
    return b;
  endfunction

  task automatic push_frame(input logic [PKT_W-1:0] p, input logic [7:0] cs);
    exp_t e;
    for (int k = 0; k < XF; k++) begin
      e.dat  = exp_byte(p, k, cs);
      e.last = (k == XF - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 400) begin
      cyc();
      t++;
    end
    check({name, "_timeout"}, int'(t < 400), 1);
    check({name, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    cyc();
    cyc();
  endtask

  // Monitor: every offered byte must match the queue head; a popped last byte demands frame_done next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pend_done = 1'b0;
      end else begin
        if (pend_done || frame_done) check("frame_done", frame_done, pend_done);
        pend_done = 1'b0;
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
          end else begin
            check("tx_data", tx_data, exp_q[0].dat);
            if (tx_ready) begin
              pend_done = exp_q[0].last;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, k, low;
    pk_hdr = '0;
    pk_hdr[15:0] = 16'h55AA;
    pk_cnt = '0;
    pk_cnt[15:0] = 16'h55AA;
    for (int i = 2; i < NB; i++) pk_cnt[8*i +: 8] = 8'(i - 1);
    pk_ff = '1;

    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (3) cyc();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    cyc();

    // Header-only frame, ready always high
    packet = pk_hdr;
    push_frame(pk_hdr, csum_of(pk_hdr));
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("tick_to_valid", tx_valid, 1);
    check("first_byte", tx_data, 8'hAA);
    nb = 0;
    for (int t = 0; t < 100 && busy; t++) begin
      nb++;
      cyc();
    end
    check("busy_cycles", nb, XF);
    wait_idle("frame1");

    // Overruns: ticks at cycles 5, 10, on the last transfer, then one accepted right after
    packet = pk_hdr;
    push_frame(pk_hdr, csum_of(pk_hdr));
    push_frame(pk_cnt, csum_of(pk_cnt));
    frame_tick = 1'b1;
    cyc();
    for (int c = 1; c <= XF + 1; c++) begin
      frame_tick = (c == 5 || c == 10 || c == XF || c == XF + 1);
      if (c == XF + 1) packet = pk_cnt;
      cyc();
      if (c == 10) check("drop_after_2", drop_cnt, 2);
      if (c == XF) begin
        check("drop_on_last", drop_cnt, 3);
        check("busy_after_last", busy, 0);
      end
      if (c == XF + 1) begin
        check("tick_after_done_busy", busy, 1);
        check("tick_after_done_valid", tx_valid, 1);
        check("tick_after_done_drop", drop_cnt, 3);
      end
    end
    frame_tick = 1'b0;
    wait_idle("overrun");

    // 300 drops while stalled saturate at 255
    tx_ready = 1'b0;
    packet = pk_hdr;
    push_frame(pk_hdr, csum_of(pk_hdr));
    frame_tick = 1'b1;
    cyc();
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 251) check("drop_254", drop_cnt, 254);
    end
    check("drop_sat", drop_cnt, 255);
    frame_tick = 1'b0;
    tx_ready = 1'b1;
    wait_idle("sat");

    // Reset after byte 7 transfers
    packet = pk_cnt;
    push_frame(pk_cnt, csum_of(pk_cnt));
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_frame_done", frame_done, 0);
    cyc();
    check("midrst_no_done", frame_done, 0);
    push_frame(pk_cnt, csum_of(pk_cnt));
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("restart_byte0", tx_data, 8'hAA);
    wait_idle("restart");

    // Ready high 1 cycle in 3, packet overwritten after the snapshot
    packet = pk_cnt;
    push_frame(pk_cnt, csum_of(pk_cnt));
    tx_ready = 1'b0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    packet = pk_ff;
    for (int t = 0; t < 300 && busy; t++) begin
      tx_ready = (t % 3 == 2);
      cyc();
    end
    tx_ready = 1'b1;
    wait_idle("stall");

    // BYTE_GAP=3 instance
    packet = pk_cnt;
    frame_tick_g = 1'b1;
    cyc();
    frame_tick_g = 1'b0;
    nb = 0;
    k = 0;
    low = 0;
    for (int t = 0; t < 300 && busy_g; t++) begin
      nb++;
      if (tx_valid_g) begin
        if (k < XF) check("gap_byte", tx_data_g, exp_byte(pk_cnt, k, csum_of(pk_cnt)));
        if (k > 0) check("gap_len", low, 3);
        k++;
        low = 0;
      end else begin
        low++;
      end
      cyc();
    end
    check("gap_frame_cycles", nb, XF + (XF - 1) * 3);
    check("gap_byte_count", k, XF);
    check("gap_frame_done", frame_done_g, 1);
    cyc();
    check("gap_frame_done_end", frame_done_g, 0);
    check("gap_drop", drop_cnt_g, 0);

    // Counting packet; with the checksum enabled the 23rd byte must be 0xD1
    packet = pk_cnt;
    push_frame(pk_cnt, 8'hD1);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    wait_idle("csum");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
